prim_demuxonehot_reg: RTL and testbench

Registered one-hot demultiplexer for valid/ready streams. It takes one input stream plus a one-hot destination mask, and steers each beat to exactly one of DATA_COUNT output lanes through a single pipeline stage. It is the fan-out counterpart of the one-hot selecting mux: the mux gathers many lanes into one, and this block scatters one stream onto many. Non-selected lanes are AND-gated to zero, so downstream one-hot OR reductions stay clean.

---
 rtl/prim_demuxonehot_reg.sv | 51 +++++
 tb/tb_prim_demuxonehot_reg.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/prim_demuxonehot_reg.sv
// prim_demuxonehot_reg: registered one-hot demux steering one valid/ready stream onto DATA_COUNT lanes
module prim_demuxonehot_reg #(
    parameter int DATA_COUNT   = 2,
    parameter int DATA_WIDTH   = 8,
    parameter bit DROP_ILLEGAL = 1'b1
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             valid_i,
    output logic                             ready_o,
    input  logic [DATA_COUNT-1:0]            mask_i,
    input  logic [DATA_WIDTH-1:0]            data_i,
    output logic [DATA_COUNT-1:0]            valid_o,
    input  logic [DATA_COUNT-1:0]            ready_i,
    output logic [DATA_COUNT*DATA_WIDTH-1:0] data_o,
    output logic                             err_o
);
    logic                  full, err_q, out_fire, in_fire, legal, take;
    logic [DATA_COUNT-1:0] sel_q, low;
    logic [DATA_WIDTH-1:0] data_q;
    // two's-complement trick isolates the lowest set bit; a mask equal to it is one-hot
    assign low      = mask_i & -mask_i;
    assign legal    = |mask_i && (low == mask_i);
    assign out_fire = full && |(sel_q & ready_i);
    assign ready_o  = !full || out_fire;
    assign in_fire  = valid_i && ready_o;
    assign take     = in_fire && (legal || (!DROP_ILLEGAL && |mask_i));
    assign valid_o  = sel_q & {DATA_COUNT{full}};
    assign err_o    = err_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full   <= 1'b0;
            sel_q  <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= in_fire && !legal;
            if (take) begin
                full   <= 1'b1;
                sel_q  <= low;
                data_q <= data_i;
            end else if (out_fire) begin
                full <= 1'b0;
            end
        end
    end
    for (genvar g = 0; g < DATA_COUNT; g++) begin : g_lane
        assign data_o[g*DATA_WIDTH +: DATA_WIDTH] = data_q & {DATA_WIDTH{valid_o[g]}};
    end
    a_valid_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(valid_o));
endmodule

// File: tb/tb_prim_demuxonehot_reg.sv
// tb_prim_demuxonehot_reg: randomized and directed checks of both drop modes against a lane-level model
module tb_prim_demuxonehot_reg;
    localparam int N = 4;
    localparam int W = 8;
    logic clk = 1'b0, rst_ni = 1'b0, valid_i = 1'b0;
    logic [N-1:0] mask_i = '0, ready_i = '0;
    logic [W-1:0] data_i = '0;
    logic [1:0] rdy, err;
    logic [1:0][N-1:0] vo;
    logic [1:0][N*W-1:0] dout;
    int n_cmp = 0, n_bad = 0;
    // index 0 drops illegal masks, index 1 routes multi-hot to the lowest lane
    bit m_full[2];
    int m_lane[2];
    logic [W-1:0] m_data[2];
    bit m_err[2];

    prim_demuxonehot_reg #(.DATA_COUNT(N), .DATA_WIDTH(W), .DROP_ILLEGAL(1'b1)) u_drop (
        .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(rdy[0]), .mask_i(mask_i),
        .data_i(data_i), .valid_o(vo[0]), .ready_i(ready_i), .data_o(dout[0]), .err_o(err[0]));
    prim_demuxonehot_reg #(.DATA_COUNT(N), .DATA_WIDTH(W), .DROP_ILLEGAL(1'b0)) u_keep (
        .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(rdy[1]), .mask_i(mask_i),
        .data_i(data_i), .valid_o(vo[1]), .ready_i(ready_i), .data_o(dout[1]), .err_o(err[1]));

    always #5 clk = ~clk;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int popc(logic [N-1:0] m);
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m[i]);
        return c;
    endfunction

    function automatic int lowest(logic [N-1:0] m);
        for (int i = 0; i < N; i++) if (m[i]) return i;
        return -1;
    endfunction

    function automatic logic m_ready(int d);
        return !m_full[d] || ready_i[m_lane[d]];
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_full[d] = 0; m_lane[d] = 0; m_data[d] = '0; m_err[d] = 0;
        end
    endtask

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            int n = popc(mask_i);
            bit drain = m_full[d] && ready_i[m_lane[d]];
            bit acc = valid_i && m_ready(d);
            m_err[d] = acc && n != 1;
            if (acc && (n == 1 || (d == 1 && n > 1))) begin
                m_full[d] = 1; m_lane[d] = lowest(mask_i); m_data[d] = data_i;
            end else if (drain) begin
                m_full[d] = 0;
            end
        end
    endtask

    task automatic check_outputs();
        for (int d = 0; d < 2; d++) begin
            logic [N-1:0] ev = m_full[d] ? N'(1 << m_lane[d]) : '0;
            logic [N*W-1:0] ed = '0;
            if (m_full[d]) ed[m_lane[d]*W +: W] = m_data[d];
            check($sformatf("valid_o[%0d]", d), 64'(vo[d]), 64'(ev));
            check($sformatf("data_o[%0d]", d), 64'(dout[d]), 64'(ed));
            check($sformatf("err_o[%0d]", d), 64'(err[d]), 64'(m_err[d]));
        end
    endtask

    // starts and ends just after a falling edge
    task automatic cyc(logic v, logic [N-1:0] m, logic [W-1:0] dat, logic [N-1:0] r);
        valid_i = v; mask_i = m; data_i = dat; ready_i = r;
        #1;
        for (int d = 0; d < 2; d++) check($sformatf("ready_o[%0d]", d), 64'(rdy[d]), 64'(m_ready(d)));
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        #1;
        check("reset_ready", 64'(rdy), 64'h3);
        check_outputs();
        // single beat to lane 2
        cyc(1, 4'b0100, 8'hA5, 4'hF);
        check("t1_valid", 64'(vo[0]), 64'h4);
        check("t1_data", 64'(dout[0]), 64'h00A5_0000);
        cyc(0, 0, 0, 4'hF);
        check("t1_drained", 64'(vo[0]), 64'h0);
        // back-to-back
        cyc(1, 4'b0001, 8'h01, 4'hF);
        cyc(1, 4'b0010, 8'h02, 4'hF);
        cyc(1, 4'b1000, 8'h03, 4'hF);
        check("t2_lane3", 64'(dout[1]), 64'h0300_0000);
        cyc(0, 0, 0, 4'hF);
        // backpressure on lane 1
        cyc(1, 4'b0010, 8'h3C, 4'b1101);
        cyc(1, 4'b0001, 8'h99, 4'b1101);
        check("t3_hold_valid", 64'(vo[0]), 64'h2);
        check("t3_hold_ready", 64'(rdy), 64'h0);
        cyc(0, 0, 0, 4'b1111);
        cyc(0, 0, 0, 4'b1111);
        // illegal masks
        cyc(1, 4'b0110, 8'hFF, 4'hF);
        check("t4_err", 64'(err), 64'h3);
        check("t4_drop_valid", 64'(vo[0]), 64'h0);
        cyc(0, 0, 0, 4'hF);
        check("t4_err_once", 64'(err), 64'h0);
        cyc(1, 4'b0000, 8'hFF, 4'hF);
        check("t4_zero_err", 64'(err), 64'h3);
        check("t4_zero_valid", 64'(vo), 64'h0);
        cyc(1, 4'b1010, 8'h55, 4'hF);
        check("t5_keep_valid", 64'(vo[1]), 64'h2);
        check("t5_keep_data", 64'(dout[1]), 64'h0000_5500);
        cyc(0, 0, 0, 4'hF);
        // async reset mid-transfer
        cyc(1, 4'b1000, 8'h77, 4'h0);
        cyc(1, 4'b0110, 8'h11, 4'h0);
        #2 rst_ni = 1'b0;
        #1;
        model_reset();
        check("t6_rst_valid", 64'(vo), 64'h0);
        check("t6_rst_data", 64'(dout[0] | dout[1]), 64'h0);
        check("t6_rst_err", 64'(err), 64'h0);
        @(negedge clk);
        rst_ni = 1'b1;
        cyc(0, 0, 0, 4'hF);
        check("t6_no_stale", 64'(vo), 64'h0);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic [N-1:0] m;
            int k = $urandom_range(0, 9);
            m = k < 7 ? N'(1 << $urandom_range(0, N-1)) : k == 7 ? '0 : N'($urandom);
            cyc(1'($urandom_range(0, 3) != 0), m, W'($urandom), N'($urandom));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
